// File: rtl/test_packet_gen.sv
// Test-traffic transmitter: back-to-back packets, each aux value sent as segment_number_max segments.
// Define TEST_PACKET_GEN_DROP_EN to skip segment DROP_SEGMENT whenever aux % DROP_PERIOD == 0.
module test_packet_gen #(
  parameter int         packetsize         = 15,
  parameter int         whereis_aux        = 0,
  parameter int         segment_number_max = 4,
  parameter int         gap_cycles         = 10,
  parameter logic [7:0] FILL_BYTE          = 8'h99
`ifdef TEST_PACKET_GEN_DROP_EN
  ,
  parameter int         DROP_PERIOD        = 5,
  parameter int         DROP_SEGMENT       = 2
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [7:0]  aux,
  output logic [7:0]  segment,
  output logic [31:0] sent_count,
  output logic [31:0] drop_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} fsm_t;

  localparam logic [15:0] LAST_IDX = 16'(packetsize - 1);
  localparam logic [15:0] AUX_IDX  = 16'(whereis_aux);
  localparam logic [15:0] LAST_GAP = 16'(gap_cycles - 1);
  localparam logic [7:0]  LAST_SEG = 8'(segment_number_max - 1);

  // The sequencer runs one cycle ahead of the outputs; every port is a
  // registered image of it, which yields the run-to-byte-0 latency of two edges.
  fsm_t        fsm_q, fsm_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  cur_aux_q, cur_aux_d;
  logic [7:0]  cur_seg_q, cur_seg_d;
  logic [15:0] pos, nxt;

  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  aux_q, aux_d;
  logic [7:0]  segment_q, segment_d;
  logic [31:0] sent_count_q, sent_count_d;
  logic [1:0]  state_q, state_d;

  function automatic logic [15:0] advance(input logic [15:0] p);
    logic [15:0] r;
    if (p[7:0] == LAST_SEG) r = {p[15:8] + 8'd1, 8'd0};
    else                    r = {p[15:8], p[7:0] + 8'd1};
    return r;
  endfunction

`ifdef TEST_PACKET_GEN_DROP_EN
  localparam bit DROP_ON = (DROP_SEGMENT < segment_number_max);

  logic        drop_pend_q, drop_pend_d;
  logic [31:0] drop_count_q, drop_count_d;

  function automatic logic drop_hit(input logic [15:0] p);
    return DROP_ON && (32'(p[7:0]) == 32'(DROP_SEGMENT)) &&
           ((32'(p[15:8]) % 32'(DROP_PERIOD)) == 32'd0);
  endfunction
`endif

  always_comb begin
    pos   = {cur_aux_q, cur_seg_q};
    nxt   = pos;
    fsm_d = fsm_q;
    idx_d = idx_q;
    gap_d = gap_q;
`ifdef TEST_PACKET_GEN_DROP_EN
    drop_pend_d = 1'b0;
`endif
    case (fsm_q)
      IDLE: begin
        if (run) begin
          fsm_d = SEND;
          idx_d = '0;
`ifdef TEST_PACKET_GEN_DROP_EN
          // Covers a drop target sitting at the very first segment after reset.
          if (drop_hit(pos)) begin
            nxt         = advance(pos);
            drop_pend_d = 1'b1;
          end
`endif
        end
      end
      SEND: begin
        if (idx_q == LAST_IDX) begin
          fsm_d = GAP;
          gap_d = '0;
          nxt   = advance(pos);
`ifdef TEST_PACKET_GEN_DROP_EN
          if (drop_hit(nxt)) begin
            nxt         = advance(nxt);
            drop_pend_d = 1'b1;
          end
`endif
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) begin
          fsm_d = run ? SEND : IDLE;
          idx_d = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
    cur_aux_d = nxt[15:8];
    cur_seg_d = nxt[7:0];
  end

  always_comb begin
    tx_en_d   = (fsm_q == SEND);
    tx_data_d = 8'h00;
    if (fsm_q == SEND) tx_data_d = (idx_q == AUX_IDX) ? cur_aux_q : FILL_BYTE;
    aux_d     = cur_aux_q;
    segment_d = cur_seg_q;
    state_d   = fsm_q;
    // First gap cycle of the sequencer lines up with the edge ending the last byte.
    sent_count_d = sent_count_q;
    if (fsm_q == GAP && gap_q == 16'd0) sent_count_d = sent_count_q + 32'd1;
`ifdef TEST_PACKET_GEN_DROP_EN
    drop_count_d = drop_count_q + {31'd0, drop_pend_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      cur_aux_q    <= '0;
      cur_seg_q    <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      aux_q        <= '0;
      segment_q    <= '0;
      sent_count_q <= '0;
      state_q      <= '0;
`ifdef TEST_PACKET_GEN_DROP_EN
      drop_pend_q  <= 1'b0;
      drop_count_q <= '0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      cur_aux_q    <= cur_aux_d;
      cur_seg_q    <= cur_seg_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      aux_q        <= aux_d;
      segment_q    <= segment_d;
      sent_count_q <= sent_count_d;
      state_q      <= state_d;
`ifdef TEST_PACKET_GEN_DROP_EN
      drop_pend_q  <= drop_pend_d;
      drop_count_q <= drop_count_d;
`endif
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign aux        = aux_q;
  assign segment    = segment_q;
  assign sent_count = sent_count_q;
  assign state      = state_q;
`ifdef TEST_PACKET_GEN_DROP_EN
  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_test_packet_gen.sv
// Bench for test_packet_gen: phase-based output model compared every cycle plus directed literal checks.
module tb_test_packet_gen;
  localparam int PKT    = 15;
  localparam int GAPC   = 10;
  localparam int WHERE  = 0;
  localparam int PERIOD = PKT + GAPC;

  logic        clk, rst, run;
  logic        tx_en;
  logic [7:0]  tx_data, aux, segment;
  logic [31:0] sent_count, drop_count;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  test_packet_gen dut (
    .clk(clk), .rst(rst), .run(run),
    .tx_en(tx_en), .tx_data(tx_data), .aux(aux), .segment(segment),
    .sent_count(sent_count), .drop_count(drop_count), .state(state)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Model: ph = -1 idle, 0..PKT-1 byte index on the wire, PKT..PERIOD-1 gap.
  int          cyc = 0;
  int          ph = -1;
  bit          pend = 0, cont = 0, m_valid = 0;
  logic [7:0]  m_aux = 0, m_seg = 0;
  logic [31:0] m_sent = 0, m_drop = 0;

  task automatic m_next_seg();
    if (m_seg == 8'd3) begin m_seg = 8'd0; m_aux = m_aux + 8'd1; end
    else m_seg = m_seg + 8'd1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = -1; pend = 0; cont = 0; m_valid = 1;
      m_aux = 0; m_seg = 0; m_sent = 0; m_drop = 0;
    end else if (m_valid) begin
      if (ph < 0) begin
        if (pend) begin
          pend = 0; ph = 0;
`ifdef TEST_PACKET_GEN_DROP_EN
          if (m_seg == 8'd2 && (m_aux % 8'd5) == 8'd0) begin m_next_seg(); m_drop++; end
`endif
        end else if (run) pend = 1;
      end else begin
        if (ph == PKT - 1) begin
          m_sent++;
          m_next_seg();
`ifdef TEST_PACKET_GEN_DROP_EN
          if (m_seg == 8'd2 && (m_aux % 8'd5) == 8'd0) begin m_next_seg(); m_drop++; end
`endif
        end
        if (ph == PERIOD - 2) cont = run;
        if (ph == PERIOD - 1) begin
          ph = cont ? 0 : -1;
          if (!cont) pend = run;
        end else ph++;
      end
    end
  end

  // Per-cycle comparison and logging.
  logic        e_tx, prev_tx = 0;
  logic [7:0]  e_data;
  logic [1:0]  e_state;
  logic [90:0] act_v, exp_v;
  int          n_tx = 0, n_fill = 0, n_gap = 0;
  int          starts[$];
  logic [7:0]  st_aux[$], st_seg[$];

  always @(negedge clk) begin
    if (m_valid) begin
      e_tx    = (ph >= 0 && ph < PKT);
      e_data  = e_tx ? ((ph == WHERE) ? m_aux : 8'h99) : 8'h00;
      e_state = (ph < 0) ? 2'd0 : (ph < PKT) ? 2'd1 : 2'd2;
      act_v = {tx_en, tx_data, aux, segment, sent_count, drop_count, state};
      exp_v = {e_tx, e_data, m_aux, m_seg, m_sent, m_drop, e_state};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle%0d outputs: got tx_en=%b data=%h aux=%h seg=%h sent=%0d drop=%0d state=%0d, model tx_en=%b data=%h aux=%h seg=%h sent=%0d drop=%0d state=%0d",
                 cyc, tx_en, tx_data, aux, segment, sent_count, drop_count, state,
                 e_tx, e_data, m_aux, m_seg, m_sent, m_drop, e_state);
      end
      if (tx_en === 1'b1) begin
        n_tx++;
        if (tx_data == 8'h99) n_fill++;
        if (!prev_tx) begin starts.push_back(cyc); st_aux.push_back(aux); st_seg.push_back(segment); end
      end
      if (state == 2'd2) n_gap++;
      prev_tx = (tx_en === 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    n_tx = 0; n_fill = 0; n_gap = 0;
    starts.delete(); st_aux.delete(); st_seg.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      tick();
      if (state == 2'd0) break;
    end
    check(name, 32'(state), 32'd0);
  endtask

  task automatic wait_tx(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (tx_en === 1'b1) break;
      tick();
    end
    check(name, 32'(tx_en), 32'd1);
  endtask

  task automatic wait_starts(input string name, input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (starts.size() >= n) break;
      tick();
    end
    check(name, 32'(starts.size()), 32'(n));
  endtask

  task automatic wait_aux(input string name, input logic [7:0] v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (aux == v) break;
      tick();
    end
    check(name, 32'(aux), 32'(v));
  endtask

`ifdef TEST_PACKET_GEN_DROP_EN
  int exp_aux[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int exp_seg[8] = '{0, 1, 3, 0, 1, 2, 3, 0};
  localparam int SEG_AFTER2 = 3;
`else
  int exp_aux[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int exp_seg[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int SEG_AFTER2 = 2;
`endif

  int badsp;

  initial begin
    rst = 1'b1; run = 1'b0;
    tick(); tick();
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_aux", 32'(aux), 32'd0);
    check("rst_segment", 32'(segment), 32'd0);
    check("rst_sent", sent_count, 32'd0);
    check("rst_drop", drop_count, 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    tick();

    // One packet: latency, byte contents, gap length.
    clear_logs();
    run = 1'b1;
    tick();
    check("t1_latency_n", 32'(tx_en), 32'd0);
    tick();
    check("t1_latency_n1", 32'(tx_en), 32'd1);
    check("t1_byte0", 32'(tx_data), 32'h00);
    run = 1'b0;
    wait_idle("t1_idle", 60);
    check("t1_tx_cycles", 32'(n_tx), 32'd15);
    check("t1_fill_bytes", 32'(n_fill), 32'd14);
    check("t1_gap_cycles", 32'(n_gap), 32'd10);
    check("t1_sent", sent_count, 32'd1);

    // Eight packets back to back.
    do_reset();
    run = 1'b1;
    wait_starts("t2_starts", 8, 8 * PERIOD + 20);
    run = 1'b0;
    wait_idle("t2_idle", 60);
    check("t2_sent", sent_count, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_aux%0d", i), 32'(st_aux[i]), 32'(exp_aux[i]));
      check($sformatf("t2_seg%0d", i), 32'(st_seg[i]), 32'(exp_seg[i]));
    end
    for (int i = 1; i < 8; i++)
      check($sformatf("t2_period%0d", i), 32'(starts[i] - starts[i-1]), 32'd25);

`ifdef TEST_PACKET_GEN_DROP_EN
    // Drop pattern up to aux 10.
    do_reset();
    run = 1'b1;
    wait_aux("t3_aux10", 8'd10, 45 * PERIOD);
    run = 1'b0;
    wait_idle("t3_idle", 60);
    check("t3_drop", drop_count, 32'd2);
    check("t3_sent", sent_count, 32'd38);
`endif

    // Long run across the aux wrap.
    do_reset();
    run = 1'b1;
    wait_starts("t4_starts", 1025, 1025 * PERIOD + 50);
    run = 1'b0;
`ifndef TEST_PACKET_GEN_DROP_EN
    check("t4_wrap_aux", 32'(aux), 32'd0);
    check("t4_wrap_seg", 32'(segment), 32'd0);
    check("t4_wrap_byte0", 32'(tx_data), 32'd0);
    check("t4_aux_255", 32'(st_aux[1023]), 32'd255);
`endif
    wait_idle("t4_idle", 60);
    check("t4_sent", sent_count, 32'd1025);
    check("t4_tx_cycles", 32'(n_tx), 32'(1025 * 15));
    badsp = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != PERIOD) badsp++;
    check("t4_spacing", 32'(badsp), 32'd0);

    // run dropped at byte 7, then resumed.
    do_reset();
    run = 1'b1;
    wait_tx("t5_first", 10);
    repeat (7) tick();
    check("t5_byte7", 32'(tx_en), 32'd1);
    run = 1'b0;
    wait_idle("t5_idle", 60);
    check("t5_tx_cycles", 32'(n_tx), 32'd15);
    check("t5_sent", sent_count, 32'd1);
    check("t5_seg_kept", 32'(segment), 32'd1);
    run = 1'b1;
    wait_tx("t5_resume", 10);
    check("t5_resume_seg", 32'(segment), 32'd1);
    check("t5_resume_byte0", 32'(tx_data), 32'd0);
    run = 1'b0;
    wait_idle("t5_idle2", 60);
    check("t5_sent2", sent_count, 32'd2);
    check("t5_seg2", 32'(segment), 32'(SEG_AFTER2));

    // Reset pulsed at byte 5 of the sixth packet.
    do_reset();
    run = 1'b1;
    wait_starts("t6_starts", 6, 6 * PERIOD + 20);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t6_tx_en", 32'(tx_en), 32'd0);
    check("t6_sent", sent_count, 32'd0);
    check("t6_aux", 32'(aux), 32'd0);
    check("t6_seg", 32'(segment), 32'd0);
    check("t6_state", 32'(state), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_restart_n1", 32'(tx_en), 32'd0);
    tick();
    check("t6_restart_n2", 32'(tx_en), 32'd1);
    check("t6_restart_byte0", 32'(tx_data), 32'd0);
    check("t6_restart_aux", 32'(aux), 32'd0);
    run = 1'b0;
    wait_idle("t6_idle", 60);
    check("t6_sent_after", sent_count, 32'd1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
